// File: rtl/int_div.sv
// int_div: radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one step per cycle.
// Define INT_DIV_SPECIAL_FAST_EN to finish divide-by-zero and signed overflow in one cycle.
module int_div (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, res_q, res_d;
  logic [1:0] op_q, op_d;
  logic q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d, ovf_q, ovf_d;
  logic sgn, div0, ovf, ge;
  logic [32:0] rem33;
  logic [31:0] diff, quo, rmd;
  // The dividend register collects quotient bits as it shifts out dividend bits.
  // With a zero divisor every step subtracts nothing, so the remainder ends up as the dividend.
  always_comb begin
    sgn = ~i_op[0];
    div0 = i_b == '0;
    ovf = sgn && i_a == 32'h8000_0000 && i_b == '1;
    rem33 = {rem_q, dvd_q[31]};
    ge = rem33 >= {1'b0, dvs_q};
    diff = rem33[31:0] - dvs_q;
    quo = div0_q ? '1 : ovf_q ? 32'h8000_0000 : q_neg_q ? -dvd_q : dvd_q;
    rmd = ovf_q ? '0 : r_neg_q ? -rem_q : rem_q;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    res_d = res_q;
    op_d = op_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    div0_d = div0_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (i_valid) begin
        op_d = i_op;
        dvd_d = sgn && i_a[31] ? -i_a : i_a;
        dvs_d = sgn && i_b[31] ? -i_b : i_b;
        rem_d = '0;
        cnt_d = '1;
        q_neg_d = sgn && (i_a[31] ^ i_b[31]);
        r_neg_d = sgn && i_a[31];
        div0_d = div0;
        ovf_d = ovf;
        state_d = CALC;
`ifdef INT_DIV_SPECIAL_FAST_EN
        if (div0 || ovf) begin
          state_d = DONE;
          res_d = i_op[1] ? (div0 ? i_a : '0) : (div0 ? '1 : 32'h8000_0000);
        end
`else
`endif
      end
      CALC: begin
        rem_d = ge ? diff : rem33[31:0];
        dvd_d = {dvd_q[30:0], ge};
        cnt_d = cnt_q - 5'd1;
        state_d = cnt_q == '0 ? FIX : CALC;
      end
      FIX: begin
        res_d = op_q[1] ? rmd : quo;
        state_d = DONE;
      end
      DONE: state_d = i_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      res_q <= '0;
      op_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      res_q <= res_d;
      op_q <= op_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      div0_q <= div0_d;
      ovf_q <= ovf_d;
    end
  end
  assign o_ready = state_q == IDLE;
  assign o_valid = state_q == DONE;
  assign o_result = res_q;
endmodule

// File: tb/tb_int_div.sv
// tb_int_div: directed and random RV32M divide checks against an arithmetic reference model.
module tb_int_div;
  logic i_clk = 1'b0;
  logic i_rst, i_valid, i_ready, o_ready, o_valid;
  logic [1:0] i_op;
  logic [31:0] i_a, i_b, o_result;
  int n_chk = 0;
  int n_fail = 0;
  always #5 i_clk = ~i_clk;
  int_div dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // RISC-V M-extension semantics; SV division truncates toward zero like RISC-V.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    case (op)
      2'd0: return $signed(a) / $signed(b);
      2'd1: return a / b;
      2'd2: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef INT_DIV_SPECIAL_FAST_EN
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`else
`endif
    return 34;
  endfunction
  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    i_op = op;
    i_a = a;
    i_b = b;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_a = $urandom;
    i_b = $urandom;
    i_op = 2'($urandom);
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
    end while (!o_valid && lat < 200);
  endtask
  task automatic consume(input string tag);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    @(negedge i_clk);
    check({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(o_ready), 32'd1);
  endtask
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    start(op, a, b);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(op, a, b)));
    check(tag, o_result, model(op, a, b));
    consume(tag);
  endtask
  initial begin
    int lat;
    logic [31:0] a, b, held;
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_op = '0;
    i_a = '0;
    i_b = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_result", o_result, 32'd0);
    i_valid = 1'b1;
    i_op = 2'd1;
    i_a = 32'd50;
    i_b = 32'd5;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    check("rst_beats_valid", 32'(o_ready), 32'd1);
    run(2'd1, 32'd100, 32'd7, "divu_100_7");
    run(2'd3, 32'd100, 32'd7, "remu_100_7");
    run(2'd0, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run(2'd2, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run(2'd0, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    run(2'd0, 32'h1234_5678, 32'd0, "div_by0");
    run(2'd1, 32'h1234_5678, 32'd0, "divu_by0");
    run(2'd2, 32'h1234_5678, 32'd0, "rem_by0");
    run(2'd3, 32'h1234_5678, 32'd0, "remu_by0");
    run(2'd0, 32'h8000_0001, 32'd0, "div_neg_by0");
    run(2'd2, 32'h8000_0001, 32'd0, "rem_neg_by0");
    run(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
    run(2'd3, 32'hFFFF_FFFF, 32'd1, "remu_max_1");
    start(2'd1, 32'd1000, 32'd7);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd34);
    held = model(2'd1, 32'd1000, 32'd7);
    check("bp_result", o_result, held);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check("bp_hold_result", o_result, held);
      check("bp_hold_ready", 32'(o_ready), 32'd0);
      check("bp_hold_valid", 32'(o_valid), 32'd1);
      i_valid = (i == 3);
      i_op = 2'd0;
      i_a = 32'd9;
      i_b = 32'd3;
    end
    consume("bp");
    @(negedge i_clk);
    check("bp_not_queued", 32'(o_ready), 32'd1);
    start(2'd0, 32'hDEAD_BEEF, 32'd13);
    repeat (10) @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("midrst_ready", 32'(o_ready), 32'd1);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_result", o_result, 32'd0);
    run(2'd1, 32'd1000, 32'd10, "after_rst_divu");
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run(2'($urandom), a, b, "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
